uart_rx_deserializer: RTL and testbench

UART receive-side deserializer: recovers LSB-first serial frames from `RX_IN` using an oversampling clock and presents them as parallel words. Each received word is reported with a one-cycle `DATA_VALID` pulse, together with parity and stop-bit error flags. It is the receiving end of the link driven by the team's UART transmit serializer, and feeds the register-file/control side of the system. The same `CLK` runs at `OVERSAMPLE` × baud rate.

---
 rtl/uart_rx_deserializer_if.sv | 12 +
 rtl/uart_rx_deserializer.sv | 119 +++++++++++
 tb/tb_uart_rx_deserializer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial line, frame options and received-word outputs of the UART deserializer
interface uart_rx_deserializer_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  modport master (output RX_IN, PAR_EN, PAR_TYP, input P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
  modport slave (input RX_IN, PAR_EN, PAR_TYP, output P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled LSB-first UART receiver with majority voting; parity support under UART_RX_PARITY_EN
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_deserializer_if.slave rx
);
  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [EW-1:0] S_LO = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] S_HI = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] DEC = EW'(OVERSAMPLE / 2 + 2);
  localparam logic [EW-1:0] LAST = EW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q;
  logic [1:0]            sync_q;
  logic [EW-1:0]         edge_q;
  logic [BW-1:0]         bit_q;
  logic [2:0]            smp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  armed_q;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;
  logic                  rx_s;
  logic                  wrap;
  logic                  decide;
  logic                  sample;
  logic                  maj;
  logic                  par_on;
  logic                  perr;
  assign rx_s = sync_q[1];
  assign wrap = edge_q == LAST;
  assign decide = edge_q == DEC;
  assign sample = edge_q >= S_LO && edge_q <= S_HI;
  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
`ifdef UART_RX_PARITY_EN
  logic perr_q;
  assign par_on = rx.PAR_EN;
  assign perr = perr_q;
  always_ff @(posedge CLK) begin
    if (RST) perr_q <= 1'b0;
    else if (state_q == IDLE) perr_q <= 1'b0;
    else if (state_q == PARITY && decide) perr_q <= maj ^ (^shift_q) ^ rx.PAR_TYP;
  end
`else
  logic unused_par;
  assign unused_par = rx.PAR_EN ^ rx.PAR_TYP;
  assign par_on = 1'b0;
  assign perr = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b1;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx.RX_IN};
      dv_q   <= 1'b0;
      pe_q   <= 1'b0;
      se_q   <= 1'b0;
      edge_q <= edge_q + EW'(1);
      if (sample) smp_q <= {smp_q[1:0], rx_s};
      case (state_q)
        IDLE: begin
          edge_q  <= '0;
          armed_q <= armed_q | rx_s;
          if (armed_q && !rx_s) begin
            state_q <= START;
            edge_q  <= EW'(1);
          end
        end
        START:
          if (decide && maj) begin
            state_q <= IDLE;
            edge_q  <= '0;
          end else if (wrap) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        DATA: begin
          if (decide) shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
          if (wrap) begin
            bit_q <= bit_q + BW'(1);
            if (bit_q == BW'(DATA_WIDTH - 1)) state_q <= par_on ? PARITY : STOP;
          end
        end
        PARITY: if (wrap) state_q <= STOP;
        STOP:
          // Leave mid-stop-bit so a start bit right after the stop bit is not missed
          if (decide) begin
            state_q <= IDLE;
            edge_q  <= '0;
            armed_q <= maj;
            dv_q    <= maj & ~perr;
            pe_q    <= perr;
            se_q    <= ~maj;
            if (maj && !perr) data_q <= shift_q;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx.P_DATA = data_q;
  assign rx.DATA_VALID = dv_q;
  assign rx.PAR_ERR = pe_q;
  assign rx.STP_ERR = se_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames with hand-computed words and pulse cycles
module tb_uart_rx_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int dv_n = 0;
  int pe_n = 0;
  int se_n = 0;
  int pe_cyc = -1;
  int se_cyc = -1;
  int dv_cyc [64];
  logic [7:0] dv_dat [64];
  uart_rx_deserializer_if #(.DATA_WIDTH(8)) u_if ();
  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(8)) dut (.CLK(clk), .RST(rst), .rx(u_if.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u_if.DATA_VALID) begin
      if (dv_n < 64) begin
        dv_cyc[dv_n] = cyc;
        dv_dat[dv_n] = u_if.P_DATA;
      end
      dv_n++;
    end
    if (u_if.PAR_ERR) begin
      pe_cyc = cyc;
      pe_n++;
    end
    if (u_if.STP_ERR) begin
      se_cyc = cyc;
      se_n++;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic v, input int spk);
    for (int c = 0; c < 8; c++) begin
      u_if.RX_IN = (c == spk) ? ~v : v;
      tick(1);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_on,
                            input logic par_bit, input int spk_bit, output int t);
    t = cyc;
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == spk_bit) ? 4 : -1);
    if (par_on) send_bit(par_bit, -1);
    send_bit(stop, -1);
    u_if.RX_IN = 1'b1;
  endtask
  initial begin
    int t;
    int t2;
    int n0;
    int s0;
    u_if.RX_IN = 1'b1;
    u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0;
    tick(3);
    check("rst_pdata", u_if.P_DATA, 0);
    check("rst_dv", u_if.DATA_VALID, 0);
    check("rst_pe", u_if.PAR_ERR, 0);
    check("rst_se", u_if.STP_ERR, 0);
    rst = 1'b0;
    tick(5);
    n0 = dv_n;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, t);
    tick(4);
    check("a5_count", dv_n - n0, 1);
    check("a5_cycle", dv_cyc[n0], t + 81);
    check("a5_data", dv_dat[n0], 'hA5);
    check("a5_hold", u_if.P_DATA, 'hA5);
    check("a5_pe", pe_n, 0);
    check("a5_se", se_n, 0);
    n0 = dv_n;
    s0 = se_n;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, t);
    u_if.RX_IN = 1'b0;
    tick(320);
    u_if.RX_IN = 1'b1;
    tick(16);
    check("brk_se_count", se_n - s0, 1);
    check("brk_se_cycle", se_cyc, t + 81);
    check("brk_no_dv", dv_n - n0, 0);
    check("brk_pdata_kept", u_if.P_DATA, 'hA5);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1, t);
    tick(4);
    check("0f_count", dv_n - n0, 1);
    check("0f_data", dv_dat[n0], 'h0F);
    check("0f_se_none", se_n - s0, 1);
    n0 = dv_n;
    s0 = se_n;
    u_if.RX_IN = 1'b0;
    tick(3);
    u_if.RX_IN = 1'b1;
    tick(20);
    check("glitch_no_dv", dv_n - n0, 0);
    check("glitch_no_se", se_n - s0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1, t);
    tick(4);
    check("81_count", dv_n - n0, 1);
    check("81_cycle", dv_cyc[n0], t + 81);
    check("81_data", dv_dat[n0], 'h81);
    n0 = dv_n;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 2, t);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, t2);
    tick(4);
    check("spike_count", dv_n - n0, 2);
    check("spike_hi_data", dv_dat[n0], 'h3C);
    check("spike_lo_data", dv_dat[n0 + 1], 'h3C);
    n0 = dv_n;
    s0 = se_n;
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mid_rst_pdata", u_if.P_DATA, 0);
    check("mid_rst_dv", u_if.DATA_VALID, 0);
    check("mid_rst_se", u_if.STP_ERR, 0);
    rst = 1'b0;
    tick(100);
    check("mid_rst_no_dv", dv_n - n0, 0);
    check("mid_rst_no_se", se_n - s0, 0);
    n0 = dv_n;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1, t);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, -1, t2);
    tick(4);
    check("b2b_count", dv_n - n0, 2);
    check("b2b_first_cycle", dv_cyc[n0], t + 81);
    check("b2b_gap", dv_cyc[n0 + 1] - dv_cyc[n0], 80);
    check("b2b_first_data", dv_dat[n0], 'h12);
    check("b2b_second_data", dv_dat[n0 + 1], 'h34);
    check("b2b_pe_none", pe_n, 0);
`ifdef UART_RX_PARITY_EN
    u_if.PAR_EN = 1'b1;
    u_if.PAR_TYP = 1'b0;
    tick(8);
    n0 = dv_n;
    s0 = pe_n;
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, -1, t);
    tick(4);
    check("par_ok_count", dv_n - n0, 1);
    check("par_ok_cycle", dv_cyc[n0], t + 89);
    check("par_ok_data", dv_dat[n0], 'h03);
    n0 = dv_n;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1, t);
    tick(4);
    check("par_err_count", pe_n - s0, 1);
    check("par_err_cycle", pe_cyc, t + 89);
    check("par_err_no_dv", dv_n - n0, 0);
    check("par_err_pdata", u_if.P_DATA, 'h03);
    u_if.PAR_TYP = 1'b1;
    n0 = dv_n;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1, t);
    tick(4);
    check("odd_ok_count", dv_n - n0, 1);
    check("odd_ok_data", dv_dat[n0], 'h07);
    u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
